spi_rx_buffer: RTL and testbench

- Receive-side consumer stage placed directly downstream of top_gen, on both leader and follower instances.
- Detects each completed SPI byte through top_gen's ready/led outputs.
- Captures the byte into a small show-ahead FIFO and drives top_gen's received acknowledge, so software and other logic no longer have to sequence received by hand.
- Adds back-pressure or drop-on-full policy, a stuck-handshake timeout, and status flags.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/spi_rx_buffer.sv | 142 ++++++++++++++
 tb/tb_spi_rx_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path.
// Contents:
//   SPI_BYTE_W       - width of one SPI data byte
//   CFG_*            - bit positions of the top_gen configuration byte fields
//   rx_state_t       - receive-buffer handshake states
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  // top_gen configuration byte layout
  localparam int CFG_MODE_BIT = 7;
  localparam int CFG_LEN_BIT  = 6;
  localparam int CFG_CPOL_BIT = 5;
  localparam int CFG_CPHA_BIT = 4;
  localparam int CFG_DIV_MSB  = 3;
  localparam int CFG_DIV_LSB  = 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    ACK        = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
// Ports:
//   clk, rst (async, active low)
//   push, wr_data   - write request and data; accepted when not full or
//                     when a pop happens in the same cycle
//   pop             - read request; ignored when empty
//   rd_data         - head entry (0 when empty)
//   count           - occupancy, one bit wider than the pointers
//   full, empty     - occupancy flags
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_buffer.sv
// Receive-side consumer for top_gen: captures each completed SPI byte into a
// show-ahead FIFO and drives top_gen's received acknowledge.
// Ports:
//   clk, rst (async, active low)
//   en          - capture enable
//   led_in      - received byte from top_gen
//   ready_in    - top_gen byte-ready, rising edge marks a new byte
//   received    - acknowledge back to top_gen
//   rd_en       - consumer pop; rd_data/rd_valid show the FIFO head
//   count, full - FIFO occupancy
//   overflow    - sticky, byte dropped on full (drop policy only)
//   timeout     - sticky, ready_in never fell while acknowledging
//   clr_flags   - clears overflow/timeout; a simultaneous set wins
//
// state      | meaning
// IDLE       | waiting for a ready_in rising edge
// WAIT_SPACE | byte pending, FIFO full, acknowledge withheld
// ACK        | received high until ready_in falls or the timeout expires
module spi_rx_buffer
  import spi_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int BLOCK_ON_FULL = 1,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [SPI_BYTE_W-1:0]   led_in,
  input  logic                    ready_in,
  output logic                    received,
  input  logic                    rd_en,
  output logic [SPI_BYTE_W-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    overflow,
  output logic                    timeout,
  input  logic                    clr_flags
);

  localparam int TMO_W = 8;

  rx_state_t        state;
  rx_state_t        state_nxt;
  logic             ready_q;
  logic             ready_rise;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_cnt_nxt;
  logic             received_nxt;
  logic             overflow_set;
  logic             timeout_set;
  logic             push;
  logic             empty;

  assign ready_rise = ready_in & ~ready_q;
  assign rd_valid   = ~empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SPI_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (led_in),
    .pop     (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_nxt    = state;
    push         = 1'b0;
    received_nxt = 1'b0;
    tmo_cnt_nxt  = '0;
    overflow_set = 1'b0;
    timeout_set  = 1'b0;
    case (state)
      IDLE: begin
        if (ready_rise && en) begin
          if (!full || rd_en) begin
            push         = 1'b1;
            received_nxt = 1'b1;
            state_nxt    = ACK;
          end else if (BLOCK_ON_FULL != 0) begin
            state_nxt = WAIT_SPACE;
          end else begin
            overflow_set = 1'b1;
            received_nxt = 1'b1;
            state_nxt    = ACK;
          end
        end
      end
      WAIT_SPACE: begin
        // led_in is only trustworthy while ready_in is high
        if (!ready_in) begin
          state_nxt = IDLE;
        end else if (rd_en || !full) begin
          push         = 1'b1;
          received_nxt = 1'b1;
          state_nxt    = ACK;
        end
      end
      ACK: begin
        if (!ready_in) begin
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_nxt   = IDLE;
        end else begin
          received_nxt = 1'b1;
          tmo_cnt_nxt  = tmo_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ready_q  <= 1'b1;  // a ready_in already high at release is not a new byte
      tmo_cnt  <= '0;
      received <= 1'b0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_q  <= ready_in;
      tmo_cnt  <= tmo_cnt_nxt;
      received <= received_nxt;
      if (overflow_set)   overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (timeout_set)    timeout  <= 1'b1;
      else if (clr_flags) timeout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Bench for spi_rx_buffer: a blocking and a dropping instance share stimulus;
// a byte queue models the expected FIFO contents.
module tb_spi_rx_buffer;
  import spi_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] led_in;
  logic       ready_in;
  logic       rd_en;
  logic       clr_flags;

  logic       rcv_b, rcv_d;
  logic [7:0] rdata_b, rdata_d;
  logic       rvalid_b, rvalid_d;
  logic [3:0] count_b, count_d;
  logic       full_b, full_d;
  logic       ovf_b, ovf_d;
  logic       tmo_b, tmo_d;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  spi_rx_buffer #(.DEPTH(DEPTH), .BLOCK_ON_FULL(1), .ACK_TIMEOUT(255)) dut_blk (
    .clk(clk), .rst(rst), .en(en), .led_in(led_in), .ready_in(ready_in),
    .received(rcv_b), .rd_en(rd_en), .rd_data(rdata_b), .rd_valid(rvalid_b),
    .count(count_b), .full(full_b), .overflow(ovf_b), .timeout(tmo_b),
    .clr_flags(clr_flags)
  );

  spi_rx_buffer #(.DEPTH(DEPTH), .BLOCK_ON_FULL(0), .ACK_TIMEOUT(255)) dut_drp (
    .clk(clk), .rst(rst), .en(en), .led_in(led_in), .ready_in(ready_in),
    .received(rcv_d), .rd_en(rd_en), .rd_data(rdata_d), .rd_valid(rvalid_d),
    .count(count_d), .full(full_d), .overflow(ovf_d), .timeout(tmo_d),
    .clr_flags(clr_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b1; ready_in = 1'b0; rd_en = 1'b0;
    clr_flags = 1'b0; led_in = 8'h00;
    tick(); tick();
    rst = 1'b1;
    tick();
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; ready_in = 1'b1; led_in = 8'h5A;
    rd_en = 1'b0; clr_flags = 1'b0;
    repeat (3) tick();
    vectors++; if (rcv_b !== 1'b0) begin miscompares++; $display("FAIL rst_rcv: got %b want 0", rcv_b); end
    vectors++; if (count_b !== 4'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", count_b); end
    vectors++; if (rvalid_b !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", rvalid_b); end
    vectors++; if ({ovf_d, tmo_d, full_d} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b want 000", {ovf_d, tmo_d, full_d}); end
    rst = 1'b1;
    repeat (4) tick();
    vectors++; if (rcv_b !== 1'b0) begin miscompares++; $display("FAIL rel_rcv: got %b want 0", rcv_b); end
    vectors++; if (count_b !== 4'd0) begin miscompares++; $display("FAIL rel_count: got %0d want 0", count_b); end
    ready_in = 1'b0; tick();
    led_in = 8'h77; ready_in = 1'b1; tick();
    vectors++; if (count_b !== 4'd1) begin miscompares++; $display("FAIL pre_async_count: got %0d want 1", count_b); end
    #2 rst = 1'b0;
    #1;
    vectors++; if ({rcv_b, rvalid_b, count_b} !== 6'b0) begin miscompares++; $display("FAIL async_rst: got %b want 000000", {rcv_b, rvalid_b, count_b}); end
    tick();
    rst = 1'b1;
    repeat (3) tick();
    vectors++; if ({rcv_b, count_b} !== 5'b0) begin miscompares++; $display("FAIL async_rel: got %b want 00000", {rcv_b, count_b}); end
    ready_in = 1'b0; tick(); tick();
  endtask

  task automatic test_single();
    do_reset();
    led_in = 8'hA5; ready_in = 1'b1; tick();
    vectors++; if (rvalid_b !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", rvalid_b); end
    vectors++; if (rdata_b !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h want a5", rdata_b); end
    vectors++; if (rcv_b !== 1'b1) begin miscompares++; $display("FAIL single_rcv_rise: got %b want 1", rcv_b); end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (rcv_b !== 1'b1) begin miscompares++; $display("FAIL single_rcv_hold%0d: got %b want 1", i, rcv_b); end
    end
    tick();
    ready_in = 1'b0; tick();
    vectors++; if (rcv_b !== 1'b0) begin miscompares++; $display("FAIL single_rcv_fall: got %b want 0", rcv_b); end
    vectors++; if (count_b !== 4'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", count_b); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    vectors++; if ({rvalid_b, count_b} !== 5'b0) begin miscompares++; $display("FAIL single_pop: got %b want 00000", {rvalid_b, count_b}); end
  endtask

  task automatic test_block_on_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      led_in = 8'(i); ready_in = 1'b1; tick();
      ready_in = 1'b0; tick(); tick();
    end
    vectors++; if ({full_b, count_b, full_d} !== 6'b1_1000_1) begin miscompares++; $display("FAIL blk_fill: got %b want 110001", {full_b, count_b, full_d}); end
    led_in = 8'h08; ready_in = 1'b1; tick();
    vectors++; if (rcv_b !== 1'b0) begin miscompares++; $display("FAIL blk_withheld: got %b want 0", rcv_b); end
    vectors++; if (dut_blk.state !== WAIT_SPACE) begin miscompares++; $display("FAIL blk_state: got %0d want %0d", dut_blk.state, WAIT_SPACE); end
    vectors++; if ({rcv_d, ovf_d} !== 2'b11) begin miscompares++; $display("FAIL drp_on_full: got %b want 11", {rcv_d, ovf_d}); end
    tick();
    vectors++; if (rcv_b !== 1'b0) begin miscompares++; $display("FAIL blk_withheld2: got %b want 0", rcv_b); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    vectors++; if (rcv_b !== 1'b1) begin miscompares++; $display("FAIL blk_ack_after_pop: got %b want 1", rcv_b); end
    vectors++; if (count_b !== 4'd8) begin miscompares++; $display("FAIL blk_count_after_pop: got %0d want 8", count_b); end
    vectors++; if (count_d !== 4'd7) begin miscompares++; $display("FAIL drp_count_after_pop: got %0d want 7", count_d); end
    ready_in = 1'b0; tick();
    vectors++; if (rcv_b !== 1'b0) begin miscompares++; $display("FAIL blk_rcv_fall: got %b want 0", rcv_b); end
    tick();
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      vectors++; if (rdata_b !== 8'(i)) begin miscompares++; $display("FAIL blk_order%0d: got %h want %h", i, rdata_b, 8'(i)); end
      if (i <= 7) begin
        vectors++; if (rdata_d !== 8'(i)) begin miscompares++; $display("FAIL drp_order%0d: got %h want %h", i, rdata_d, 8'(i)); end
      end
      tick();
    end
    rd_en = 1'b0;
    vectors++; if ({count_b, count_d} !== 8'h00) begin miscompares++; $display("FAIL blk_drained: got %h want 00", {count_b, count_d}); end
  endtask

  task automatic test_drop_on_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      q.push_back(b);
      led_in = b; ready_in = 1'b1; tick();
      ready_in = 1'b0; tick(); tick();
    end
    led_in = 8'h6A; ready_in = 1'b1; tick();
    vectors++; if ({rcv_d, ovf_d} !== 2'b11) begin miscompares++; $display("FAIL drp_ack_ovf: got %b want 11", {rcv_d, ovf_d}); end
    vectors++; if (count_d !== 4'd8) begin miscompares++; $display("FAIL drp_count: got %0d want 8", count_d); end
    vectors++; if ({rcv_b, ovf_b} !== 2'b00) begin miscompares++; $display("FAIL blk_no_ovf: got %b want 00", {rcv_b, ovf_b}); end
    ready_in = 1'b0; tick(); tick();
    vectors++; if (rcv_d !== 1'b0) begin miscompares++; $display("FAIL drp_rcv_fall: got %b want 0", rcv_d); end
    vectors++; if (count_b !== 4'd8) begin miscompares++; $display("FAIL blk_abandon_count: got %0d want 8", count_b); end
    vectors++; if (dut_blk.state !== IDLE) begin miscompares++; $display("FAIL blk_abandon_state: got %0d want %0d", dut_blk.state, IDLE); end
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    vectors++; if (ovf_d !== 1'b0) begin miscompares++; $display("FAIL drp_clr: got %b want 0", ovf_d); end
    led_in = 8'h6B; ready_in = 1'b1; clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    vectors++; if (ovf_d !== 1'b1) begin miscompares++; $display("FAIL drp_set_wins: got %b want 1", ovf_d); end
    ready_in = 1'b0; tick(); tick();
    rd_en = 1'b1;
    while (q.size() > 0) begin
      vectors++; if (rdata_d !== q[0] || rdata_b !== q[0]) begin miscompares++; $display("FAIL drp_drain: got %h/%h want %h", rdata_b, rdata_d, q[0]); end
      void'(q.pop_front());
      tick();
    end
    rd_en = 1'b0;
  endtask

  task automatic test_timeout();
    int hi;
    do_reset();
    led_in = 8'h3C; ready_in = 1'b1; tick();
    hi = 0;
    for (int c = 0; c < 300; c++) begin
      if (rcv_b === 1'b1) hi++;
      tick();
    end
    vectors++; if (hi !== 255) begin miscompares++; $display("FAIL tmo_cycles: got %0d want 255", hi); end
    vectors++; if ({tmo_b, tmo_d} !== 2'b11) begin miscompares++; $display("FAIL tmo_flag: got %b want 11", {tmo_b, tmo_d}); end
    vectors++; if (rcv_b !== 1'b0) begin miscompares++; $display("FAIL tmo_rcv: got %b want 0", rcv_b); end
    ready_in = 1'b0; tick(); tick();
    vectors++; if (count_b !== 4'd1 || rdata_b !== 8'h3C) begin miscompares++; $display("FAIL tmo_fifo: got %0d/%h want 1/3c", count_b, rdata_b); end
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    vectors++; if ({tmo_b, tmo_d} !== 2'b00) begin miscompares++; $display("FAIL tmo_clr: got %b want 00", {tmo_b, tmo_d}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    led_in = 8'h11; ready_in = 1'b1; tick();
    ready_in = 1'b0; tick(); tick();
    led_in = 8'h0F; ready_in = 1'b1; rd_en = 1'b1; tick(); rd_en = 1'b0;
    vectors++; if (count_b !== 4'd1 || count_d !== 4'd1) begin miscompares++; $display("FAIL b2b_count: got %0d/%0d want 1", count_b, count_d); end
    vectors++; if (rdata_b !== 8'h0F) begin miscompares++; $display("FAIL b2b_head: got %h want 0f", rdata_b); end
    vectors++; if (rcv_b !== 1'b1) begin miscompares++; $display("FAIL b2b_rcv: got %b want 1", rcv_b); end
    ready_in = 1'b0; tick(); tick();
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0; led_in = 8'h99; ready_in = 1'b1; tick(); tick();
    vectors++; if ({rcv_b, count_b} !== 5'b0) begin miscompares++; $display("FAIL en_off: got %b want 00000", {rcv_b, count_b}); end
    en = 1'b1; tick();
    vectors++; if ({rcv_b, count_b} !== 5'b0) begin miscompares++; $display("FAIL en_late: got %b want 00000", {rcv_b, count_b}); end
    ready_in = 1'b0; tick(); tick();
  endtask

  task automatic test_random();
    logic ovf_exp;
    do_reset();
    ovf_exp = 1'b0;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic [7:0] b;
        logic       e, exp_rb, exp_rd;
        int         hold;
        b    = 8'($urandom);
        e    = ($urandom_range(0, 5) != 0);
        hold = $urandom_range(1, 4);
        if (!e) begin
          exp_rb = 1'b0; exp_rd = 1'b0;
        end else if (q.size() < DEPTH) begin
          q.push_back(b); exp_rb = 1'b1; exp_rd = 1'b1;
        end else begin
          exp_rb = 1'b0; exp_rd = 1'b1; ovf_exp = 1'b1;
        end
        en = e; led_in = b; ready_in = 1'b1; tick();
        vectors++; if ({rcv_b, rcv_d} !== {exp_rb, exp_rd}) begin miscompares++; $display("FAIL rnd%0d_rcv: got %b want %b", n, {rcv_b, rcv_d}, {exp_rb, exp_rd}); end
        vectors++; if ({ovf_b, ovf_d} !== {1'b0, ovf_exp}) begin miscompares++; $display("FAIL rnd%0d_ovf: got %b want %b", n, {ovf_b, ovf_d}, {1'b0, ovf_exp}); end
        repeat (hold - 1) tick();
        ready_in = 1'b0; tick(); tick();
        en = 1'b1;
      end else begin
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
      end
      vectors++; if (count_b !== 4'(q.size()) || count_d !== 4'(q.size())) begin miscompares++; $display("FAIL rnd%0d_count: got %0d/%0d want %0d", n, count_b, count_d, q.size()); end
      vectors++; if ({rvalid_b, rvalid_d} !== {2{q.size() > 0}}) begin miscompares++; $display("FAIL rnd%0d_valid: got %b%b want %0d", n, rvalid_b, rvalid_d, q.size() > 0); end
      if (q.size() > 0) begin
        vectors++; if (rdata_b !== q[0] || rdata_d !== q[0]) begin miscompares++; $display("FAIL rnd%0d_head: got %h/%h want %h", n, rdata_b, rdata_d, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_block_on_full();
    test_drop_on_full();
    test_timeout();
    test_back_to_back();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
